// File: rtl/lfsr_crypt_pkg.sv
// Shared keystream definition for the LFSR stream encrypter/decrypter pair.
// Both ends import this package so their keystreams cannot drift apart.
package lfsr_crypt_pkg;

   localparam int LFSR_W = 16;
   localparam int DATA_W = 8;
   localparam logic [LFSR_W-1:0] TAPS         = 16'hB400;  // x^16+x^14+x^13+x^11+1
   localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;  // replaces an all-zero seed

   typedef enum logic {
      ST_UNSEEDED = 1'b0,
      ST_RUN      = 1'b1
   } dec_state_t;

   // One Galois step: shift right, fold the taps in when a one falls out.
   function automatic logic [LFSR_W-1:0] galois_step(input logic [LFSR_W-1:0] s);
      galois_step = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   // DATA_W steps unrolled into one combinational cloud: one byte's worth of keystream.
   function automatic logic [LFSR_W-1:0] lfsr_adv8(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] r;
      r = s;
      for (int i = 0; i < DATA_W; i++) begin
         r = galois_step(r);
      end
      lfsr_adv8 = r;
   endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// Keystream generator: LFSR state register with zero-seed substitution and
// a byte-wide advance. ks is the low byte of the state before the advance.
module lfsr_keystream
   import lfsr_crypt_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              adv,
   output logic [DATA_W-1:0] ks
);

   logic [LFSR_W-1:0] lfsr;

   // State register: load wins over advance; an all-zero seed would lock up, so substitute.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= SEED_DEFAULT;
      end else if (load) begin
         lfsr <= (seed == '0) ? SEED_DEFAULT : seed;
      end else if (adv) begin
         lfsr <= lfsr_adv8(lfsr);
      end
   end

   assign ks = lfsr[DATA_W-1:0];

endmodule

// File: rtl/lfsr_stream_decrypt.sv
// Receive-side stream decrypter: XORs ciphertext bytes with the regenerated
// keystream, one registered output stage, byte counter and seed status.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holding valid keeps its data stable until that edge, and
// ready may depend combinationally on the other side's signals.
module lfsr_stream_decrypt
   import lfsr_crypt_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              seeded,
   output logic              seed_err,
   output logic [15:0]       byte_count
);

   dec_state_t        state, state_nxt;
   logic              accept;
   logic [DATA_W-1:0] ks;

   lfsr_keystream u_ks (
      .clk  (clk),
      .rst  (rst),
      .load (seed_load),
      .seed (seed_in),
      .adv  (accept),
      .ks   (ks)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_UNSEEDED;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: the first seed load starts the stream; later loads just reseed.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_UNSEEDED: if (seed_load) state_nxt = ST_RUN;
         ST_RUN:      state_nxt = ST_RUN;
         default:     state_nxt = ST_UNSEEDED;
      endcase
   end

   // Accept only when seeded, not reseeding, and the output slot is free or draining.
   always_comb begin
      in_ready = (state == ST_RUN) && !seed_load && (!out_valid || out_ready);
      accept   = in_valid && in_ready;
   end

   assign seeded = (state == ST_RUN);

   // Output stage, counter and seed flag; a seed load flushes the pending byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         seed_err   <= 1'b0;
         byte_count <= '0;
      end else if (seed_load) begin
         out_valid  <= 1'b0;
         seed_err   <= (seed_in == '0);
         byte_count <= '0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_data   <= in_data ^ ks;
         byte_count <= byte_count + 16'd1;
      end else if (out_valid && out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Self-checking bench for lfsr_stream_decrypt: vector table of seed/byte
// cases, hand-written backpressure/flush/wrap/reset sequences and a
// scoreboard queue of expected plaintext bytes.
module tb_lfsr_stream_decrypt;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_load;
   logic [15:0] seed_in;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        seeded;
   logic        seed_err;
   logic [15:0] byte_count;

   lfsr_stream_decrypt dut (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .seeded     (seeded),
      .seed_err   (seed_err),
      .byte_count (byte_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] seed;
      logic [7:0]  din;
      logic [7:0]  dout;
      logic        err;
   } vec_t;

   vec_t        vecs [5];
   logic [7:0]  exp_q [$];
   logic [15:0] m_lfsr;
   logic [15:0] e_lfsr;
   logic [7:0]  pend_exp;
   logic        rand_ready;
   logic        acc;
   int          n_checks;
   int          n_fail;

   // Independent reference LFSR: polynomial x^16+x^14+x^13+x^11+1, right-shifting.
   function automatic logic [15:0] model_adv(input logic [15:0] s);
      logic [15:0] r;
      r = s;
      for (int k = 0; k < 8; k++) begin
         r = {1'b0, r[15:1]} ^ ({16{r[0]}} & 16'hB400);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: monitor at negedge (pop then push), inputs change 1ns after posedge.
   task automatic cycle();
      @(negedge clk);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected none", out_data);
         end else begin
            check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
         end
      end
      acc = in_valid && in_ready;
      if (acc) begin
         exp_q.push_back(pend_exp);
         m_lfsr = model_adv(m_lfsr);
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send_exp(input logic [7:0] d, input logic [7:0] e);
      bit got;
      got = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      pend_exp = e;
      for (int t = 0; t < 200 && !got; t++) begin
         cycle();
         got = acc;
      end
      in_valid = 1'b0;
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: got no accept expected accept of %0h", d);
      end
   endtask

   task automatic send(input logic [7:0] d);
      send_exp(d, d ^ m_lfsr[7:0]);
   endtask

   task automatic load_seed(input logic [15:0] s);
      seed_in   = s;
      seed_load = 1'b1;
      #1;
      check("in_ready_during_load", {31'd0, in_ready}, 32'd0);
      cycle();
      seed_load = 1'b0;
      exp_q.delete();
      m_lfsr = (s == 16'd0) ? 16'hACE1 : s;
   endtask

   task automatic drain();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) cycle();
      cycle();
      check("drain_queue_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rand_ready = 1'b0;
      m_lfsr = 16'hACE1;
      vecs[0] = '{seed: 16'h0001, din: 8'h41, dout: 8'h40, err: 1'b0};
      vecs[1] = '{seed: 16'h0000, din: 8'hE1, dout: 8'h00, err: 1'b1};
      vecs[2] = '{seed: 16'hACE1, din: 8'hE1, dout: 8'h00, err: 1'b0};
      vecs[3] = '{seed: 16'hBEEF, din: 8'h00, dout: 8'hEF, err: 1'b0};
      vecs[4] = '{seed: 16'hFFFF, din: 8'hFF, dout: 8'h00, err: 1'b0};

      // Reset with in_valid asserted.
      rst = 1'b1; seed_load = 1'b0; seed_in = '0;
      in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1; pend_exp = 8'h00;
      #3;
      check("rst_seeded", {31'd0, seeded}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
      check("rst_seed_err", {31'd0, seed_err}, 32'd0);
      check("rst_byte_count", {16'd0, byte_count}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("unseeded_in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;

      // Vector table: seed, one byte, known plaintext and seed_err.
      for (int i = 0; i < 5; i++) begin
         load_seed(vecs[i].seed);
         check("seeded_after_load", {31'd0, seeded}, 32'd1);
         check("seed_err", {31'd0, seed_err}, {31'd0, vecs[i].err});
         send_exp(vecs[i].din, vecs[i].dout);
         drain();
         check("byte_count_one", {16'd0, byte_count}, 32'd1);
      end

      // Seed 1: two bytes, second held under backpressure for 5 cycles.
      load_seed(16'h0001);
      check("seed_err_cleared", {31'd0, seed_err}, 32'd0);
      out_ready = 1'b0;
      send_exp(8'h41, 8'h40);
      in_valid = 1'b1; in_data = 8'h68; pend_exp = 8'h00;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_out_data", {24'd0, out_data}, 32'h40);
         cycle();
      end
      out_ready = 1'b1;
      cycle();
      check("pop_and_accept", {31'd0, acc}, 32'd1);
      check("pop_accept_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b0;
      drain();
      check("byte_count_two", {16'd0, byte_count}, 32'd2);

      // 64 random bytes with random backpressure and idle gaps.
      load_seed(16'h5A5A);
      rand_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if ($urandom_range(0, 3) == 0) cycle();
         send(8'($urandom_range(0, 255)));
      end
      drain();
      check("byte_count_64", {16'd0, byte_count}, 32'd64);

      // Round trip against an encrypter model seeded with BEEF.
      load_seed(16'hBEEF);
      e_lfsr = 16'hBEEF;
      rand_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] p;
         p = 8'($urandom_range(0, 255));
         send_exp(p ^ e_lfsr[7:0], p);
         e_lfsr = model_adv(e_lfsr);
      end
      drain();
      check("byte_count_256", {16'd0, byte_count}, 32'd256);

      // Reseed mid-stream flushes the pending byte and restarts the keystream.
      load_seed(16'h1234);
      out_ready = 1'b0;
      send(8'h11);
      check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
      load_seed(16'hBEEF);
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_byte_count", {16'd0, byte_count}, 32'd0);
      out_ready = 1'b1;
      send_exp(8'h00, 8'hEF);
      drain();

      // Counter wrap after 65536 accepts.
      load_seed(16'h0001);
      out_ready = 1'b1;
      for (int i = 0; i < 65535; i++) send(8'(i));
      check("byte_count_ffff", {16'd0, byte_count}, 32'h0000FFFF);
      send(8'hA5);
      check("byte_count_wrap", {16'd0, byte_count}, 32'd0);
      drain();

      // Asynchronous reset with a pending output byte.
      load_seed(16'h0001);
      out_ready = 1'b0;
      send_exp(8'h41, 8'h40);
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("async_rst_seeded", {31'd0, seeded}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      cycle();
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("final_queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
